// File: rtl/ident_vec_sequencer.sv
// Stimulus sequencer and identity checker: walks a vector memory, drives the
// reference and synthesized instances, and compares their outputs per vector.
module ident_vec_sequencer #(
  parameter int IN_W   = 86,
  parameter int OUT_W  = 81,
  parameter int ADDR_W = 5,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic [ADDR_W:0]   vec_count,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  ref_y,
  input  logic [OUT_W-1:0]  syn_y,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [OUT_W-1:0]  sig
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W:0] MAX_CNT     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE - 1);

  logic [2:0]        state;
  logic [ADDR_W:0]   count;
  logic              stop_mode;
  logic [3:0]        settle_cnt;
  logic              mismatch;
  logic              last;

  // Case inequality so an X on either side counts as a mismatch.
  always_comb begin
    mismatch = (ref_y !== syn_y);
    last     = ({1'b0, vec_addr} == (count - ONE_CNT));
    busy     = (state == S_FETCH) || (state == S_LOAD) ||
               (state == S_SETTLE) || (state == S_CAPTURE);
    done     = (state == S_DONE);
  end

  // vec_addr doubles as the vector index, so it is already stable during FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      stop_mode  <= 1'b0;
      settle_cnt <= '0;
      vec_addr   <= '0;
      dut_in     <= '0;
      fail       <= 1'b0;
      fail_idx   <= '0;
      fail_cnt   <= '0;
      sig        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            stop_mode <= stop_on_fail;
            count     <= (vec_count > MAX_CNT) ? MAX_CNT : vec_count;
            vec_addr  <= '0;
            fail      <= 1'b0;
            fail_idx  <= '0;
            fail_cnt  <= '0;
            sig       <= '0;
            state     <= (vec_count != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          dut_in     <= vec_data;
          settle_cnt <= SETTLE_INIT;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == '0) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          sig <= {sig[OUT_W-2:0], sig[OUT_W-1]} ^ ref_y;
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + ONE_CNT;
            if (!fail) begin
              fail     <= 1'b1;
              fail_idx <= vec_addr;
            end
          end
          if ((mismatch && stop_mode) || last) begin
            state <= S_DONE;
          end else begin
            vec_addr <= vec_addr + 1'b1;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ident_vec_sequencer.md
# ident_vec_sequencer

Synthesizable stimulus sequencer and identity checker for the differential simulation flow. It walks a vector memory and drives each packed input vector onto a pair of instances of the same `top` design: the RTL reference and the synthesized netlist. After a programmable settle time it captures and compares both 81-bit `y` outputs. It records the first failing vector index, the failure count and a rolling signature of the reference output, so a run can be checked without per-cycle output dumps.

## Interface
Parameters:
- `IN_W`, 86: packed stimulus width, `{wire4[20:0], wire3[19:0], wire2[8:0], wire1[16:0], wire0[18:0]}`, MSB-first.
- `OUT_W`, 81: width of `y` on each instance.
- `ADDR_W`, 5: vector memory address width; depth is 2^ADDR_W.
- `SETTLE`, 1: cycles between applying a vector and capturing outputs; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop_on_fail`  in  1  sampled with `start`; 1 ends the run at the first mismatch.
- `vec_count`  in  ADDR_W+1  number of vectors to apply; sampled with `start`; values above 2^ADDR_W are clamped.
- `vec_addr`  out  ADDR_W  vector memory read address.
- `vec_data`  in  IN_W  memory read data, valid one cycle after `vec_addr`.
- `dut_in`  out  IN_W  packed stimulus to both instances; slice [85:65] = wire4, … , [18:0] = wire0.
- `ref_y`, `syn_y`  in  OUT_W  outputs of the reference and the synthesized instance.
- `busy`  out  1  a run is in progress.
- `done`  out  1  level; run complete; held until the next accepted `start`.
- `fail`  out  1  sticky; at least one mismatch in this run.
- `fail_idx`  out  ADDR_W  index of the first mismatching vector.
- `fail_cnt`  out  ADDR_W+1  number of mismatching vectors; saturates at all-ones.
- `sig`  out  OUT_W  rolling signature of `ref_y`.

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, CAPTURE, DONE.
- IDLE:
  - `start`=1 latches `stop_on_fail` and the clamped `vec_count`.
  - Clears `done`, `fail`, `fail_idx`, `fail_cnt`, `sig` and the index.
  - Goes to FETCH if the count is nonzero, otherwise to DONE.
- FETCH: drive `vec_addr` = index; go to LOAD.
- LOAD: `dut_in` <= `vec_data`; load the settle counter with SETTLE-1; go to SETTLE.
- SETTLE: decrement the counter; go to CAPTURE after the cycle in which the counter reads 0.
- CAPTURE:
  - `sig` <= {`sig`[OUT_W-2:0], `sig`[OUT_W-1]} ^ `ref_y`.
  - If `ref_y` != `syn_y` (any bit, including X on either side):
    - `fail_cnt`++ (saturating).
    - On the first mismatch only: set `fail` and `fail_idx` = index.
  - Go to DONE if (mismatch and `stop_on_fail`) or index == count-1; otherwise index++ and go to FETCH.
- DONE: `done`=1 and `busy`=0; `start` behaves as in IDLE, so DONE also accepts a new run.
- `busy` is 1 in FETCH through CAPTURE.
- `start` is ignored while `busy`.
- `dut_in` holds its last value after the run ends.
- Reset value of every output is 0. Reset mid-run aborts the run immediately and asynchronously; no partial results are kept.

## Timing
- Cycles per vector: 3 + SETTLE.
- With the accepting edge as cycle 0, `done` is high in cycle 1 + N·(3+SETTLE), where N is the number of vectors actually applied.
- `vec_count`=0: `done` is high in cycle 1; `busy` never asserts.
- `vec_addr` is registered. `vec_data` is sampled exactly one cycle after the FETCH cycle.
- `fail`, `fail_idx`, `fail_cnt` and `sig` all update on the same CAPTURE edge.
- `ref_y`/`syn_y` are sampled only on the CAPTURE edge; values at any other time have no effect.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation → every output is 0 at once, state is IDLE, and a following `start` runs normally.
- Clean run (SETTLE=1), `vec_count`=3, `ref_y`==`syn_y` → `vec_addr` sequence 0,1,2; `done` high 13 cycles after start; `fail`=0, `fail_cnt`=0.
- Signature: 2 vectors with `ref_y`=1 constant → `sig`=1 after the first capture, 3 after the second.
- Continue on fail: `vec_count`=4, `stop_on_fail`=0, `syn_y` differs on vectors 2 and 3 → `fail`=1, `fail_idx`=2, `fail_cnt`=2, `done` at cycle 17.
- Stop on fail: `vec_count`=4, `stop_on_fail`=1, mismatches on vectors 1 and 2 → `done` at cycle 9, `fail_idx`=1, `fail_cnt`=1, vector 2 never fetched.
- Edge counts: `vec_count`=0 → `done` at cycle 1. `vec_count`=40 with ADDR_W=5 → 32 vectors applied, `vec_addr` runs 0..31, and `start` pulses during the run are ignored.
